// File: rtl/csel_add_pkg.sv
// Shared types and constants for the limb-serial carry-select add scheduler.
package csel_add_pkg;

  localparam int unsigned LIMB = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/csel_add_sched_adder.sv
// 22-bit carry-select adder: 11-bit ripple low half, high half precomputed
// for both carry values and selected by the low-half carry.
module C_Sel_A_22bit (
  input  logic [21:0] a,
  input  logic [21:0] b,
  input  logic        cin,
  output logic [21:0] sum,
  output logic        cout
);

  logic [11:0] lo;
  logic [11:0] hi0;
  logic [11:0] hi1;

  assign lo  = {1'b0, a[10:0]}  + {1'b0, b[10:0]}  + {11'b0, cin};
  assign hi0 = {1'b0, a[21:11]} + {1'b0, b[21:11]};
  assign hi1 = {1'b0, a[21:11]} + {1'b0, b[21:11]} + 12'd1;

  assign sum  = {(lo[11] ? hi1[10:0] : hi0[10:0]), lo[10:0]};
  assign cout = lo[11] ? hi1[11] : hi0[11];

endmodule

// File: rtl/csel_add_sched.sv
// Two-requester multi-precision add scheduler; runs each WORDS*LIMB add
// limb-serially through one shared carry-select adder, LSB limb first.
module csel_add_sched
  import csel_add_pkg::*;
#(
  parameter int unsigned LIMB  = csel_add_pkg::LIMB,
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [LIMB*WORDS-1:0] req0_a,
  input  logic [LIMB*WORDS-1:0] req0_b,
  input  logic                  req0_cin,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [LIMB*WORDS-1:0] req1_a,
  input  logic [LIMB*WORDS-1:0] req1_b,
  input  logic                  req1_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [LIMB*WORDS-1:0] rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_id
);

  localparam int unsigned W  = LIMB * WORDS;
  localparam int unsigned IW = idx_width(WORDS);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d, cout_q, cout_d, id_q, id_d, prio_q, prio_d;

  logic            gnt0, gnt1;
  logic [LIMB-1:0] limb_a, limb_b, limb_sum;
  logic            limb_cout;
  int unsigned     base;

  // prio_q names the requester that wins a tie
  assign gnt0 = req0_valid & (~req1_valid | ~prio_q);
  assign gnt1 = req1_valid & (~req0_valid |  prio_q);

  always_comb begin
    base   = LIMB * 32'(idx_q);
    limb_a = a_q[base +: LIMB];
    limb_b = b_q[base +: LIMB];
  end

  C_Sel_A_22bit u_adder (
    .a    (limb_a),
    .b    (limb_b),
    .cin  (carry_q),
    .sum  (limb_sum),
    .cout (limb_cout)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    id_d       = id_q;
    prio_d     = prio_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 | gnt1) begin
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          carry_d = gnt1 ? req1_cin : req0_cin;
          id_d    = gnt1;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: LIMB] = limb_sum;
        carry_d = limb_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(WORDS - 1)) begin
          cout_d  = limb_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule
